// File: rtl/twoscomp_arb_pkg.sv
// Shared types and defaults for the two's-complement engine arbiter.
package twoscomp_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = $clog2(DEF_N_REQ);

endpackage

// File: rtl/twoscomp_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module twoscomp_rr_pick
  import twoscomp_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] sel_idx,
  output logic [N_REQ-1:0] onehot
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    any     = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any     = 1'b1;
        sel_idx = IDX_W'(idx);
      end
    end
    onehot = any ? (ONE << sel_idx) : '0;
  end

endmodule

// File: rtl/twoscomp_arbiter.sv
// Round-robin arbiter/sequencer sharing one negation engine among N_REQ requesters.
// Optional WAIT timeout compiled in with `define TWOSCOMP_ARB_TIMEOUT_EN.
module twoscomp_arbiter
  import twoscomp_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               eng_start,
  output logic [W-1:0]       eng_in,
  input  logic [W-1:0]       eng_out,
  input  logic               eng_done
);

  localparam int               IDX_W = idx_width(N_REQ);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_sel_idx;
  logic             w_any;
  logic [IDX_W-1:0] w_sel;
  logic [N_REQ-1:0] w_onehot;
  logic             w_timeout;

  twoscomp_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .any     (w_any),
    .sel_idx (w_sel),
    .onehot  (w_onehot)
  );

`ifdef TWOSCOMP_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT);
  logic [CNT_W-1:0] r_to_cnt;

  // Fires on the WAIT edge that would bring the count to TIMEOUT; done has priority.
  assign w_timeout = (r_state == WAIT) && !eng_done && (r_to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT && !eng_done) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (eng_done || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_sel_idx <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_in    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      busy      <= (w_state_nxt != IDLE);
      gnt       <= '0;
      eng_start <= 1'b0;
      rsp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt       <= w_onehot;
            r_sel_idx <= w_sel;
            eng_in    <= req_data[w_sel*W +: W];
            eng_start <= 1'b1;
          end
        end
        WAIT: begin
          // ISSUE never looks at eng_done, so a level left over from the last job is ignored.
          if (eng_done) begin
            rsp_data  <= eng_out;
            rsp_valid <= ONE << r_sel_idx;
            rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            rsp_data  <= '0;
            rsp_valid <= ONE << r_sel_idx;
            rsp_err   <= 1'b1;
          end
        end
        RESP: begin
          r_ptr <= (r_sel_idx == IDX_W'(N_REQ - 1)) ? '0 : r_sel_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twoscomp_arbiter.sv
// Self-checking bench for twoscomp_arbiter: vector table, engine model and response scoreboard.
module tb_twoscomp_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           eng_start;
  logic [W-1:0]   eng_in;
  logic [W-1:0]   eng_out;
  logic           eng_done;

  twoscomp_arbiter #(
    .N_REQ   (N),
    .W       (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_in    (eng_in),
    .eng_out   (eng_out),
    .eng_done  (eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    logic [W-1:0] res;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  int   checks;
  int   errors;
  int   rsp_count;
  int   eng_mode;   // 0: done 3 cycles after start, 1: done stuck high, 2: never done
  int   eng_cnt;
  exp_t sb[$];
  exp_t sb_head;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Engine model, updated mid-cycle so the DUT sees stable levels at posedge.
  always @(negedge clk) begin
    if (reset) begin
      eng_done = 1'b0;
      eng_cnt  = 0;
    end else begin
      case (eng_mode)
        1: begin
          eng_done = 1'b1;
          eng_out  = ~eng_in + 1'b1;
        end
        2: eng_done = 1'b0;
        default: begin
          eng_done = 1'b0;
          if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
              eng_done = 1'b1;
              eng_out  = ~eng_in + 1'b1;
            end
          end
          if (eng_start) eng_cnt = 3;
        end
      endcase
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (|rsp_valid)) begin
      rsp_count++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        sb_head = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(oh(sb_head.idx)));
        check("rsp_data", 32'(rsp_data), 32'(sb_head.data));
        check("rsp_err", 32'(rsp_err), 32'(sb_head.err));
      end
    end
    if (!reset && (|gnt)) check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
  end

  task automatic push_exp(input int idx, input logic [W-1:0] d, input logic e);
    exp_t x;
    x.idx  = idx;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((sb.size() != 0 || busy) && t < 200);
    check("drain_done", 32'(sb.size() == 0 && !busy), 32'd1);
    sb.delete();
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int t = 0; t < 100 && g == '0; t++) begin
      @(negedge clk);
      g = gnt;
    end
    check("gnt_arrives", 32'(|g), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_in"}, 32'(eng_in), 32'd0);
  endtask

  // One isolated transaction issued from IDLE; grant must follow on the next edge.
  task automatic do_txn(input int idx, input logic [W-1:0] d, input logic [W-1:0] r);
    req[idx]              = 1'b1;
    req_data[idx*W +: W]  = d;
    @(negedge clk);
    check("txn_gnt", 32'(gnt), 32'(oh(idx)));
    check("txn_eng_start", 32'(eng_start), 32'd1);
    check("txn_eng_in", 32'(eng_in), 32'(d));
    check("txn_busy", 32'(busy), 32'd1);
    req[idx] = 1'b0;
    push_exp(idx, r, 1'b0);
    drain();
    check("txn_rsp_data_hold", 32'(rsp_data), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    int           base;
    int           n;
    logic         prev0;
    logic [W-1:0] all_res[4];

    checks    = 0;
    errors    = 0;
    rsp_count = 0;
    eng_mode  = 0;
    eng_cnt   = 0;
    eng_done  = 1'b0;
    eng_out   = '0;
    req       = '0;
    req_data  = '0;
    reset     = 1'b1;

    vecs[0] = '{idx: 1, data: 8'h05, res: 8'hFB};
    vecs[1] = '{idx: 0, data: 8'h80, res: 8'h80};
    vecs[2] = '{idx: 2, data: 8'h00, res: 8'h00};
    vecs[3] = '{idx: 3, data: 8'h7F, res: 8'h81};
    vecs[4] = '{idx: 1, data: 8'hFF, res: 8'h01};
    vecs[5] = '{idx: 2, data: 8'h01, res: 8'hFF};

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vecs[i].idx, vecs[i].data, vecs[i].res);

    // All four at once from ptr = 0: served 0,1,2,3.
    apply_reset();
    all_res  = '{8'h00, 8'hFF, 8'h80, 8'h81};
    req_data = {8'h7F, 8'h80, 8'h01, 8'h00};
    req      = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      check("all4_order", 32'(g), 32'(oh(k)));
      req[k] = 1'b0;
      push_exp(k, all_res[k], 1'b0);
    end
    drain();

    // Fairness between two continuously held requesters.
    req_data[0*W +: W] = 8'h10;
    req_data[2*W +: W] = 8'h33;
    req   = 4'b0101;
    prev0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_gnt(g);
      check("fair_gnt", 32'(g), 32'(oh((k % 2 == 0) ? 0 : 2)));
      check("fair_no_repeat0", 32'(prev0 && g[0]), 32'd0);
      prev0 = g[0];
      if (k == 7) req = '0;
      push_exp((k % 2 == 0) ? 0 : 2, (k % 2 == 0) ? 8'hF0 : 8'hCD, 1'b0);
    end
    drain();

    // Done held high: ISSUE must ignore it, WAIT takes it on the next edge.
    eng_mode = 1;
    base     = rsp_count;
    for (int r = 0; r < 2; r++) begin
      req[2]           = 1'b1;
      req_data[2*W +: W] = (r == 0) ? 8'h02 : 8'h45;
      @(negedge clk);
      check("stale_eng_start", 32'(eng_start), 32'd1);
      req[2] = 1'b0;
      push_exp(2, (r == 0) ? 8'hFE : 8'hBB, 1'b0);
      @(negedge clk);
      check("stale_no_early_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("stale_rsp_2edges", 32'(rsp_valid), 32'(oh(2)));
      drain();
    end
    check("stale_one_rsp_per_gnt", 32'(rsp_count - base), 32'd2);
    eng_mode = 0;
    @(negedge clk);

    // Reset during WAIT: outputs clear at once, in-flight result discarded.
    req[1]             = 1'b1;
    req_data[1*W +: W] = 8'h40;
    @(negedge clk);
    check("rstw_gnt", 32'(gnt), 32'(oh(1)));
    req[1] = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_all_zero("rst_async");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base  = rsp_count;
    repeat (8) @(negedge clk);
    check("rst_no_rsp", 32'(rsp_count - base), 32'd0);
    do_txn(3, 8'h01, 8'hFF);

    // Engine that never completes.
    eng_mode = 2;
    @(negedge clk);
    base               = rsp_count;
    req[0]             = 1'b1;
    req_data[0*W +: W] = 8'h09;
    @(negedge clk);
    check("to_eng_start", 32'(eng_start), 32'd1);
    req[0] = 1'b0;
`ifdef TWOSCOMP_ARB_TIMEOUT_EN
    push_exp(0, 8'h00, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 100);
    check("to_latency", 32'(n), 32'(TO + 1));
    drain();
    check("to_rsp_err_hold", 32'(rsp_err), 32'd1);
`else
    n = 0;
    repeat (40) @(negedge clk);
    check("nto_busy_held", 32'(busy), 32'd1);
    check("nto_no_rsp", 32'(rsp_count - base), 32'd0);
    apply_reset();
    check("nto_busy_cleared", 32'(busy), 32'd0);
`endif
    eng_mode = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
